// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_pkg;

    localparam int MD_SIZE = 32;
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - iteration counter with clear, enable and terminal count at SIZE-1
module multdiv_counter #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CNT_W'(SIZE - 1));

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed Booth multiplier / restoring divider, fixed 33-cycle latency
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int SIZE  = MD_SIZE,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ctrl_MULT,
    input  logic            ctrl_DIV,
    input  logic [SIZE-1:0] data_operandA,
    input  logic [SIZE-1:0] data_operandB,
    output logic [SIZE-1:0] data_result,
    output logic            data_exception,
    output logic            data_resultRDY,
    output logic            busy
);

    // Shared accumulator: MULT uses {33-bit high, 32-bit low, q-1}, DIV uses {pad, 33-bit rem, 32-bit quo}.
    localparam int AW = 2 * SIZE + 2;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [SIZE-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic              dz_q, dz_d;
    logic [SIZE-1:0]   result_q, result_d;
    logic              exc_q, exc_d;

    logic              start;
    logic              tc;
    logic [CNT_W-1:0]  count;
    logic              done_entry;

    logic [SIZE:0]     booth_hi;
    logic [AW-1:0]     mult_step;
    logic [SIZE:0]     r_sh;
    logic [SIZE+1:0]   diff;
    logic [AW-1:0]     div_step;
    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   quo_mag;
    logic [SIZE-1:0]   a_mag, b_mag;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign done_entry = (state_q == ST_RUN) && tc && !start;

    multdiv_counter #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i    (clock),
        .resetn_i (reset_n),
        .clr_i    (start),
        .en_i     (state_q == ST_RUN),
        .count_o  (count),
        .tc_o     (tc)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (start) state_d = ST_RUN;
                     else if (tc) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q == ST_RUN);
        data_resultRDY = (state_q == ST_DONE);
    end

    // One iteration of each algorithm; the 33-bit Booth high half absorbs -(-2^31).
    always_comb begin
        booth_hi = acc_q[AW-1:SIZE+1];
        case (acc_q[1:0])
            2'b01:   booth_hi = acc_q[AW-1:SIZE+1] + {opnd_q[SIZE-1], opnd_q};
            2'b10:   booth_hi = acc_q[AW-1:SIZE+1] - {opnd_q[SIZE-1], opnd_q};
            default: booth_hi = acc_q[AW-1:SIZE+1];
        endcase
        mult_step = {booth_hi[SIZE], booth_hi, acc_q[SIZE:1]};

        r_sh     = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
        diff     = {1'b0, r_sh} - {2'b00, opnd_q};
        div_step = diff[SIZE+1] ? {1'b0, r_sh, acc_q[SIZE-2:0], 1'b0}
                                : {1'b0, diff[SIZE:0], acc_q[SIZE-2:0], 1'b1};

        prod    = mult_step[2*SIZE:1];
        quo_mag = div_step[SIZE-1:0];
        a_mag   = data_operandA[SIZE-1] ? -data_operandA : data_operandA;
        b_mag   = data_operandB[SIZE-1] ? -data_operandB : data_operandB;
    end

    always_comb begin
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (start) begin
            neg_d = data_operandA[SIZE-1] ^ data_operandB[SIZE-1];
            dz_d  = (data_operandB == '0);
            if (ctrl_MULT) begin
                op_d   = OP_MULT;
                acc_d  = {{(SIZE+1){1'b0}}, data_operandB, 1'b0};
                opnd_d = data_operandA;
            end else begin
                op_d   = OP_DIV;
                acc_d  = {{(SIZE+2){1'b0}}, a_mag};
                opnd_d = b_mag;
            end
        end else if (state_q == ST_RUN) begin
            acc_d = (op_q == OP_MULT) ? mult_step : div_step;
            if (done_entry) begin
                if (op_q == OP_MULT) begin
                    result_d = prod[SIZE-1:0];
                    exc_d    = (prod[2*SIZE-1:SIZE] != {SIZE{prod[SIZE-1]}});
                end else if (dz_q) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = neg_q ? -quo_mag : quo_mag;
                    exc_d    = !neg_q && quo_mag[SIZE-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q     <= OP_MULT;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule
